div16s_8_seq: RTL
=================

Name: div16s_8_seq

Overview:
- Sequential signed divider for the 8-bit signed multiplier family: the inverse operation of the 8x8 signed multipliers.
- Takes a 16-bit signed dividend (a product-format word) and an 8-bit signed divisor. Returns an 8-bit signed quotient and an 8-bit signed remainder.
- Serves as the exact reference path that recovers operands from products when characterising approximate multipliers, and as a general datapath divider.
- Radix-2 restoring algorithm, one quotient bit per cycle, with valid/ready handshakes on input and output.

Parameters:
- DW, 8, operand/result width; dividend is 2*DW bits, iteration count is 2*DW.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- A  in  2*DW  signed dividend
- B  in  DW  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- Q  out  DW  signed quotient, saturated on overflow
- R  out  DW  signed remainder
- ovf  out  1  quotient did not fit in DW signed bits
- dz  out  1  divisor was zero

Behaviour:
- Reset: synchronous, active-high. While rst=1 and on the first cycle after:
  - state=IDLE; out_valid=0; Q=0; R=0; ovf=0; dz=0.
  - in_ready=0 while rst=1, then 1 in IDLE.
- Reset mid-operation aborts the operation. No result is produced for the aborted operation.
- States and transitions:
  - IDLE: in_ready=1. On in_valid & in_ready, register A and B, then go to PREP.
  - PREP:
    - Compute the 2*DW-bit unsigned magnitude |A| and the DW-bit unsigned magnitude |B|. A=-32768 gives 32768; B=-128 gives 128.
    - Record the quotient sign sA^sB and the remainder sign sA.
    - If B==0: load the dz result and go to DONE. Otherwise clear the partial remainder and go to CALC.
  - CALC: 2*DW iterations, MSB first. Each iteration:
    - Shift the next dividend bit into the partial remainder (DW+1 bits).
    - Subtract |B| if the result is non-negative.
    - Shift the quotient bit into the 2*DW-bit magnitude quotient.
  - FIX: apply signs to form the result, then go to DONE.
  - DONE: out_valid=1. Q, R, ovf and dz stay stable while out_ready=0. On out_ready, go to IDLE and drop out_valid on the next cycle.
- Latency, counted from the accepting edge:
  - Normal operation: out_valid=1 for the first time 2*DW+3 cycles later (19 for DW=8).
  - Divide by zero: 2 cycles.
- Throughput: in_ready=0 from PREP through DONE. At least one IDLE cycle separates back-to-back operations.
- Arithmetic:
  - Truncating division toward zero. The remainder takes the sign of the dividend, or is 0. The identity A = Q*B + R holds whenever ovf=0.
  - Overflow: if the signed quotient is outside [-2^(DW-1), 2^(DW-1)-1], set ovf=1 and saturate Q to 127 (positive) or -128 (negative).
  - R is always exact. |R| < |B| ≤ 128, so R always fits in DW bits.
  - Divide by zero: dz=1, ovf=0. Q=127 if A≥0, Q=-128 if A<0. R=A[DW-1:0].
- in_valid is ignored while in_ready=0. A and B are sampled only on the accepting edge. Changes to A/B afterwards have no effect.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- A=100, B=-7 -> Q=-14, R=2, ovf=0, dz=0. out_valid rises 19 cycles after acceptance.
- A=-100, B=7 -> Q=-14, R=-2.
- A=-895, B=7 -> Q=-127, R=-6, ovf=0.
- A=16384, B=-128 -> Q=-128, R=0, ovf=0 (exact boundary).
- A=900, B=7 -> ovf=1, Q=127, R=4.
- A=-32768, B=-1 -> ovf=1, Q=127, R=0.
- A=-5, B=0 -> dz=1, Q=-128, R=-5 (0xFB). out_valid 2 cycles after acceptance.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> Q/R/flags stable, in_ready=0. Then pulse out_ready -> out_valid falls next cycle and in_ready=1.
- Assert rst at CALC cycle 8 -> out_valid stays 0. A new op 50/5 afterwards returns Q=10, R=0.
- Random signed A/B sweep against a golden model -> identity, ovf and dz match.

Source files
------------

// File: rtl/div16s_8_seq.sv
// div16s_8_seq
// Sequential signed divider: a 2*DW-bit signed dividend divided by a DW-bit
// signed divisor. It produces a DW-bit signed quotient that truncates toward
// zero and saturates on overflow, and a DW-bit signed remainder.
// The core is a radix-2 restoring divider on magnitudes that retires one
// quotient bit per cycle.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   in_valid   operand pair valid
//   in_ready   block can accept operands (registered)
//   A          signed dividend, 2*DW bits
//   B          signed divisor, DW bits
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   Q          signed quotient, saturated when ovf=1
//   R          signed remainder, sign of dividend or zero
//   ovf        quotient did not fit in DW signed bits
//   dz         divisor was zero
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A and B are sampled only on the input transfer edge. Q/R/ovf/dz
// hold steady while out_valid=1 and out_ready=0. in_valid is ignored while
// in_ready=0.
module div16s_8_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] A,
    input  logic [DW-1:0]   B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   Q,
    output logic [DW-1:0]   R,
    output logic            ovf,
    output logic            dz
);

    localparam int CW = $clog2(2*DW);
    localparam logic [CW-1:0]   LAST_IT = CW'(2*DW-1);
    localparam logic [DW-1:0]   Q_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   Q_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [2*DW-1:0] POS_LIM = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [2*DW-1:0] NEG_LIM = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state_q;
    logic [2*DW-1:0] a_q;
    logic [DW-1:0]   b_q;
    logic [DW-1:0]   mag_b_q;
    logic [2*DW-1:0] div_q;     // dividend magnitude shifts out, quotient shifts in
    logic [DW-1:0]   rem_q;     // partial remainder, always < |B| <= 2^(DW-1)
    logic [CW-1:0]   cnt_q;
    logic            qneg_q;
    logic            rneg_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [DW-1:0]   q_q;
    logic [DW-1:0]   r_q;
    logic            ovf_q;
    logic            dz_q;

    logic [2*DW-1:0] mag_a_d;
    logic [DW-1:0]   mag_b_d;
    logic [DW:0]     rem_sh;
    logic [DW:0]     rem_sub;
    logic            rem_ge;
    logic [DW:0]     rem_d;
    logic [2*DW-1:0] div_d;
    logic [DW-1:0]   q_fix_d;
    logic [DW-1:0]   r_fix_d;
    logic            ovf_fix_d;
    logic [DW-1:0]   q_dz_d;
    logic            unused_rem_msb;

    always_comb begin
        mag_a_d   = a_q[2*DW-1] ? (~a_q + 1'b1) : a_q;
        mag_b_d   = b_q[DW-1] ? (~b_q + 1'b1) : b_q;

        // One restoring step: shift in the next dividend bit, keep the
        // difference only when it did not go negative.
        rem_sh    = {rem_q, div_q[2*DW-1]};
        rem_sub   = rem_sh - {1'b0, mag_b_q};
        rem_ge    = (rem_sh >= {1'b0, mag_b_q});
        rem_d     = rem_ge ? rem_sub : rem_sh;
        div_d     = {div_q[2*DW-2:0], rem_ge};

        // Negative quotients may reach magnitude 2^(DW-1), positive ones
        // only 2^(DW-1)-1.
        ovf_fix_d = 1'b0;
        q_fix_d   = div_q[DW-1:0];
        if (qneg_q) begin
            if (div_q > NEG_LIM) begin
                ovf_fix_d = 1'b1;
                q_fix_d   = Q_MIN;
            end else begin
                q_fix_d   = ~div_q[DW-1:0] + 1'b1;
            end
        end else if (div_q > POS_LIM) begin
            ovf_fix_d = 1'b1;
            q_fix_d   = Q_MAX;
        end
        r_fix_d   = rneg_q ? (~rem_q + 1'b1) : rem_q;
        q_dz_d    = a_q[2*DW-1] ? Q_MIN : Q_MAX;
    end

    // The kept remainder is below |B|, so the top bit is always zero.
    assign unused_rem_msb = rem_d[DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mag_b_q     <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_q        <= A;
                        b_q        <= B;
                        in_ready_q <= 1'b0;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    div_q   <= mag_a_d;
                    mag_b_q <= mag_b_d;
                    qneg_q  <= a_q[2*DW-1] ^ b_q[DW-1];
                    rneg_q  <= a_q[2*DW-1];
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    if (b_q == '0) begin
                        q_q     <= q_dz_d;
                        r_q     <= a_q[DW-1:0];
                        ovf_q   <= 1'b0;
                        dz_q    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d[DW-1:0];
                    div_q <= div_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IT) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    q_q     <= q_fix_d;
                    r_q     <= r_fix_d;
                    ovf_q   <= ovf_fix_d;
                    dz_q    <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE; the
                    // result registers are already settled by then.
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign R         = r_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule
